systolic_load_ctrl: RTL and testbench

SYSTOLIC_LOAD_CTRL -- requirements
Module: systolic_load_ctrl

---
 rtl/sys_ctrl_pkg.sv | 20 ++
 rtl/systolic_load_ctrl.sv | 101 ++++++++++
 tb/tb_systolic_load_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - shared state type and default sizing for the systolic load controller
package sys_ctrl_pkg;

   localparam int DEF_DEPTH       = 8;
   localparam int DEF_STREAM_MULT = 3;
   localparam int DEF_STREAM_LEN  = DEF_STREAM_MULT * DEF_DEPTH;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } ctrl_state_t;

   // Bits needed to hold every value 0..max_val (at least one bit)
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/systolic_load_ctrl.sv
// rtl/systolic_load_ctrl.sv - loads DEPTH matrix rows into the transpose FIFO, then streams them
module systolic_load_ctrl
   import sys_ctrl_pkg::*;
#(
   parameter int DEPTH      = DEF_DEPTH,
   parameter int STREAM_LEN = DEF_STREAM_MULT * DEPTH
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     stall,
   output logic                     rd_req,
   output logic [$clog2(DEPTH)-1:0] rd_addr,
   input  logic                     rd_valid,
   output logic                     WrEn,
   output logic [$clog2(DEPTH)-1:0] Arow,
   output logic                     en,
   output logic                     busy,
   output logic                     done
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = cnt_width(STREAM_LEN);
   localparam logic [AW-1:0] LAST_ROW  = AW'(DEPTH - 1);
   localparam logic [SW-1:0] LAST_BEAT = SW'(STREAM_LEN - 1);

   ctrl_state_t   r_state;
   logic [AW-1:0] r_row;
   logic [SW-1:0] r_beat;

   logic w_load_active;
   logic w_stream_active;

   // Abort suppresses every strobe in the cycle it is seen, so the active flags fold it in
   assign w_load_active   = (r_state == ST_LOAD)   && !abort;
   assign w_stream_active = (r_state == ST_STREAM) && !abort;

   // Row data is written in the same cycle the memory returns it, hence no register on WrEn/en
   assign rd_req  = w_load_active;
   assign rd_addr = r_row;
   assign WrEn    = w_load_active && rd_valid;
   assign Arow    = r_row;
   assign en      = w_stream_active && !stall;
   assign busy    = (r_state != ST_IDLE);
   assign done    = (r_state == ST_DONE);

   // Sequencer: IDLE -> LOAD (DEPTH handshakes) -> STREAM (STREAM_LEN beats) -> DONE -> IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_row   <= '0;
         r_beat  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_LOAD;
                  r_row   <= '0;
                  r_beat  <= '0;
               end
            end
            ST_LOAD: begin
               if (abort) begin
                  r_state <= ST_IDLE;
                  r_row   <= '0;
               end else if (rd_valid) begin
                  if (r_row == LAST_ROW) begin
                     r_state <= ST_STREAM;
                     r_row   <= '0;
                  end else begin
                     r_row <= r_row + 1'b1;
                  end
               end
            end
            ST_STREAM: begin
               if (abort) begin
                  r_state <= ST_IDLE;
                  r_beat  <= '0;
               end else if (!stall) begin
                  if (r_beat == LAST_BEAT) begin
                     r_state <= ST_DONE;
                     r_beat  <= '0;
                  end else begin
                     r_beat <= r_beat + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_row   <= '0;
               r_beat  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_load_ctrl.sv
// tb/tb_systolic_load_ctrl.sv - vector table, directed sequences and random model check
module tb_systolic_load_ctrl;
   import sys_ctrl_pkg::*;

   localparam int DEPTH = 8;
   localparam int SLEN  = 3 * DEPTH;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          stall = 1'b0;
   logic          rd_valid = 1'b0;
   logic          rd_req, WrEn, en, busy, done;
   logic [AW-1:0] rd_addr, Arow;

   int n_total = 0;
   int n_pass  = 0;

   logic          s_rd_req, s_WrEn, s_en, s_busy, s_done;
   logic [AW-1:0] s_addr, s_arow;

   int   we_cyc[$];
   int   we_row[$];
   int   en_cyc[$];
   int   done_cyc[$];
   int   req_cnt, addr_bad, we_bad;
   logic busy_tr[0:63];

   systolic_load_ctrl #(.DEPTH(DEPTH), .STREAM_LEN(SLEN)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
      .WrEn(WrEn), .Arow(Arow), .en(en), .busy(busy), .done(done)
   );

   // 10 time-unit clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Sample outputs at the falling edge, then step just past the next rising edge
   task automatic tick();
      @(negedge clk);
      s_rd_req = rd_req; s_WrEn = WrEn; s_en = en; s_busy = busy; s_done = done;
      s_addr = rd_addr; s_arow = Arow;
      chk("wren_en_exclusive", {31'd0, WrEn & en}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   function automatic bit rows_ok();
      if (we_row.size() != DEPTH) return 1'b0;
      for (int i = 0; i < DEPTH; i++) if (we_row[i] != i) return 1'b0;
      return 1'b1;
   endfunction

   // One operation started in cycle 0; lat=0 ties rd_valid high, else each row answers after lat cycles
   task automatic run_op(input int lat, input int stall_from, input int stall_len,
                         input int xs1, input int xs2, input int ncyc);
      int   k;
      logic prev_req, prev_we;
      logic [AW-1:0] prev_addr;
      we_cyc.delete(); we_row.delete(); en_cyc.delete(); done_cyc.delete();
      req_cnt = 0; addr_bad = 0; we_bad = 0; k = 0;
      prev_req = 1'b0; prev_we = 1'b0; prev_addr = '0;
      abort = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         start = (c == 0) || (c == xs1) || (c == xs2);
         stall = (c >= stall_from) && (c < stall_from + stall_len);
         if (lat == 0) rd_valid = 1'b1;
         else if (rd_req) begin k++; rd_valid = (k == lat); end
         else begin k = 0; rd_valid = 1'b0; end
         tick();
         if (s_WrEn) begin we_cyc.push_back(c); we_row.push_back(int'(s_arow)); k = 0; end
         if (s_WrEn && !rd_valid) we_bad++;
         if (s_rd_req) begin
            req_cnt++;
            if (prev_req && !prev_we && s_addr != prev_addr) addr_bad++;
         end
         prev_req = s_rd_req; prev_we = s_WrEn; prev_addr = s_addr;
         if (s_en) en_cyc.push_back(c);
         if (s_done) done_cyc.push_back(c);
         if (c < 64) busy_tr[c] = s_busy;
      end
      start = 1'b0; stall = 1'b0; rd_valid = 1'b0;
   endtask

   typedef struct {
      logic       st;
      logic       ab;
      logic       stl;
      logic       rv;
      logic [4:0] exp;   // {rd_req, WrEn, en, busy, done}
      int         addr;
   } vec_t;

   vec_t tbl[13];

   int   m_ph, m_rows, m_str, en_cnt, ops;
   int   q_rows[$];
   int   n_we, n_dn, n_bz;
   logic e_req, e_we, e_en, e_busy, e_done;
   bit   seq_ok;

   // Main test sequence
   initial begin
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'b00000, 0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b10010, 0};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b10010, 0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b11010, 0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b11010, 1};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'b00010, 2};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 0};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b00000, 0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b11010, 0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00010, 1};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 0};

      // reset state, with start held to show it is ignored under reset
      start = 1'b1; rd_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tick();
      chk("reset_outputs", {27'd0, s_rd_req, s_WrEn, s_en, s_busy, s_done}, 32'd0);
      chk("reset_addr", {29'd0, s_addr}, 32'd0);
      start = 1'b0; rd_valid = 1'b0;
      rst_n = 1'b1;

      // vector table
      for (int i = 0; i < 13; i++) begin
         start = tbl[i].st; abort = tbl[i].ab; stall = tbl[i].stl; rd_valid = tbl[i].rv;
         tick();
         chk($sformatf("tbl%0d_ctl", i), {27'd0, s_rd_req, s_WrEn, s_en, s_busy, s_done},
             {27'd0, tbl[i].exp});
         chk($sformatf("tbl%0d_addr", i), {26'd0, s_addr, s_arow},
             {26'd0, AW'(tbl[i].addr), AW'(tbl[i].addr)});
      end
      start = 1'b0; abort = 1'b0; stall = 1'b0; rd_valid = 1'b0;

      // zero-latency load
      run_op(0, 1000, 0, -1, -1, 40);
      chk("z_we_count", we_cyc.size(), DEPTH);
      chk("z_we_first", we_cyc[0], 1);
      chk("z_we_last", we_cyc[DEPTH-1], 8);
      chk("z_rows", {31'd0, rows_ok()}, 1);
      chk("z_en_count", en_cyc.size(), SLEN);
      chk("z_en_first", en_cyc[0], 9);
      chk("z_en_last", en_cyc[SLEN-1], 32);
      chk("z_done", done_cyc.size() == 1 ? done_cyc[0] : -1, 33);
      chk("z_idle_after", {31'd0, busy_tr[34]}, 0);

      // latency-3 memory
      run_op(3, 1000, 0, -1, -1, 60);
      chk("l3_req_cycles", req_cnt, 24);
      chk("l3_addr_stable", addr_bad, 0);
      chk("l3_we_only_valid", we_bad, 0);
      chk("l3_rows", {31'd0, rows_ok()}, 1);
      chk("l3_we_first", we_cyc[0], 3);
      chk("l3_we_last", we_cyc[DEPTH-1], 24);
      chk("l3_en_count", en_cyc.size(), SLEN);
      chk("l3_done", done_cyc.size() == 1 ? done_cyc[0] : -1, 49);

      // 5-cycle stall in the middle of the stream
      run_op(0, 15, 5, -1, -1, 50);
      n_we = 0;
      foreach (en_cyc[i]) if (en_cyc[i] >= 15 && en_cyc[i] <= 19) n_we++;
      chk("st_en_in_stall", n_we, 0);
      chk("st_en_count", en_cyc.size(), SLEN);
      chk("st_en_resume", en_cyc[6], 20);
      chk("st_done", done_cyc.size() == 1 ? done_cyc[0] : -1, 38);

      // start pulses while busy and in the DONE cycle
      run_op(0, 1000, 0, 4, 33, 40);
      chk("sb_we_first", we_cyc[0], 1);
      chk("sb_we_count", we_cyc.size(), DEPTH);
      chk("sb_done", done_cyc.size() == 1 ? done_cyc[0] : -1, 33);
      chk("sb_no_restart", {30'd0, busy_tr[34], busy_tr[35]}, 0);

      // abort at row 4, then reload from row 0
      rd_valid = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 4; c++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_addr", {29'd0, s_addr}, 4);
      chk("ab_strobes_low", {28'd0, s_rd_req, s_WrEn, s_en, s_done}, 0);
      chk("ab_busy_in_cycle", {31'd0, s_busy}, 1);
      n_we = 0; n_dn = 0; n_bz = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_we += int'(s_WrEn); n_dn += int'(s_done); n_bz += int'(s_busy);
      end
      chk("ab_after_we", n_we, 0);
      chk("ab_after_done", n_dn, 0);
      chk("ab_after_busy", n_bz, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("ab_reload_row0", {28'd0, s_WrEn, s_arow}, {28'd0, 1'b1, {AW{1'b0}}});

      // asynchronous reset mid-stream
      for (int c = 0; c < 9; c++) tick();
      @(negedge clk);
      #2;
      chk("rs_pre_en", {30'd0, en, busy}, 32'd3);
      rst_n = 1'b0;
      #1;
      chk("rs_async", {27'd0, rd_req, WrEn, en, busy, done}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_bz = 0;
      for (int c = 0; c < 5; c++) begin tick(); n_bz += int'(s_busy) + int'(s_en); end
      chk("rs_discarded", n_bz, 0);

      // random stimulus against a rule-level model
      m_ph = 0; m_rows = 0; m_str = 0; en_cnt = 0; ops = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         start    = ($urandom_range(0, 3) == 0);
         abort    = ($urandom_range(0, 40) == 0);
         stall    = ($urandom_range(0, 3) == 0);
         rd_valid = ($urandom_range(0, 2) == 0);
         e_req  = (m_ph == 1) && !abort;
         e_we   = (m_ph == 1) && rd_valid && !abort;
         e_en   = (m_ph == 2) && !stall && !abort;
         e_busy = (m_ph != 0);
         e_done = (m_ph == 3);
         tick();
         chk("rnd_vec", {21'd0, s_rd_req, s_WrEn, s_en, s_busy, s_done, s_addr, s_arow},
             {21'd0, e_req, e_we, e_en, e_busy, e_done, AW'(m_rows), AW'(m_rows)});
         if (s_WrEn) q_rows.push_back(int'(s_arow));
         if (s_en) en_cnt++;
         if (s_done) begin
            ops++;
            seq_ok = (q_rows.size() == DEPTH);
            foreach (q_rows[i]) if (q_rows[i] != i) seq_ok = 1'b0;
            chk("rnd_row_seq", {31'd0, seq_ok}, 1);
            chk("rnd_en_total", en_cnt, SLEN);
         end
         case (m_ph)
            0: if (start) begin m_ph = 1; m_rows = 0; q_rows.delete(); en_cnt = 0; end
            1: if (abort) begin m_ph = 0; m_rows = 0; end
               else if (rd_valid) begin
                  m_rows++;
                  if (m_rows == DEPTH) begin m_ph = 2; m_rows = 0; m_str = 0; end
               end
            2: if (abort) begin m_ph = 0; m_str = 0; end
               else if (!stall) begin
                  m_str++;
                  if (m_str == SLEN) m_ph = 3;
               end
            default: m_ph = 0;
         endcase
      end
      chk("rnd_ops_completed", {31'd0, ops > 0}, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
